// File: rtl/umi_address_remap_cfg.sv
`default_nettype none
// umi_address_remap_cfg: shadow/active remap table and dstaddr window with atomic commit. Rev 1.0.
// Register readback is built only when UMI_REMAP_CFG_READBACK_EN is defined.
module umi_address_remap_cfg #(
   parameter int CW    = 32,
   parameter int AW    = 64,
   parameter int DW    = 64,
   parameter int IDW   = 16,
   parameter int NMAPS = 8
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 cfg_req_valid,
   output logic                 cfg_req_ready,
   input  logic [CW-1:0]        cfg_req_cmd,
   input  logic [AW-1:0]        cfg_req_dstaddr,
   input  logic [AW-1:0]        cfg_req_srcaddr,
   input  logic [DW-1:0]        cfg_req_data,
   output logic                 cfg_resp_valid,
   input  logic                 cfg_resp_ready,
   output logic [CW-1:0]        cfg_resp_cmd,
   output logic [AW-1:0]        cfg_resp_dstaddr,
   output logic [AW-1:0]        cfg_resp_srcaddr,
   output logic [DW-1:0]        cfg_resp_data,
   input  logic                 remap_idle,
   output logic [IDW*NMAPS-1:0] old_row_col_address,
   output logic [IDW*NMAPS-1:0] new_row_col_address,
   output logic [AW-1:0]        set_dstaddress_low,
   output logic [AW-1:0]        set_dstaddress_high,
   output logic [AW-1:0]        set_dstaddress_offset,
   output logic                 commit_pending
);

   localparam logic [4:0] REQ_READ   = 5'h01;
   localparam logic [4:0] REQ_WRITE  = 5'h03;
   localparam logic [4:0] REQ_POSTED = 5'h05;
   localparam logic [4:0] RESP_READ  = 5'h02;
   localparam logic [4:0] RESP_WRITE = 5'h04;
   localparam int         IW         = (NMAPS > 1) ? $clog2(NMAPS) : 1;
   localparam logic [8:0] NMAPS_W    = 9'(NMAPS);

   typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;
   state_t state, state_nxt;

   logic [IDW-1:0] sh_old  [NMAPS];
   logic [IDW-1:0] sh_new  [NMAPS];
   logic [IDW-1:0] act_old [NMAPS];
   logic [IDW-1:0] act_new [NMAPS];
   logic [AW-1:0]  sh_low, sh_high, sh_off;

   logic [4:0]    opc;
   logic [11:0]   off;
   logic [IW-1:0] idx;
   logic          shape_ok, hit_entry, hit_low, hit_high, hit_off, hit_ctrl, hit_status, mapped;
   logic          is_read, is_write, is_posted, wr_ok, rd_ok;
   logic          req_fire, wr_en, apply;
   logic [DW-1:0] rd_data;
   logic [CW-1:0] resp_cmd_nxt;
   logic          unused_req_bits;

   assign opc        = cfg_req_cmd[4:0];
   assign off        = cfg_req_dstaddr[11:0];
   assign idx        = off[3 +: IW];
   assign shape_ok   = (cfg_req_cmd[7:5] == 3'd3) && (cfg_req_cmd[15:8] == 8'd0);
   assign hit_entry  = (off[2:0] == 3'b000) && (off[11:3] < NMAPS_W);
   assign hit_low    = (off == 12'h100);
   assign hit_high   = (off == 12'h108);
   assign hit_off    = (off == 12'h110);
   assign hit_ctrl   = (off == 12'h118);
   assign hit_status = (off == 12'h120);
   assign mapped     = hit_entry | hit_low | hit_high | hit_off | hit_ctrl | hit_status;
   assign is_read    = (opc == REQ_READ);
   assign is_write   = (opc == REQ_WRITE);
   assign is_posted  = (opc == REQ_POSTED);
   assign wr_ok      = (is_write | is_posted) & shape_ok & mapped & ~hit_status;
   assign unused_req_bits = ^{cfg_req_cmd[CW-1:16], cfg_req_dstaddr[AW-1:12]};

`ifdef UMI_REMAP_CFG_READBACK_EN
   assign rd_ok = is_read & shape_ok & mapped;

   always_comb begin
      rd_data = '0;
      if (hit_entry) begin
         rd_data[IDW-1:0]   = sh_old[idx];
         rd_data[IDW+31:32] = sh_new[idx];
      end else if (hit_low) begin
         rd_data = DW'(sh_low);
      end else if (hit_high) begin
         rd_data = DW'(sh_high);
      end else if (hit_off) begin
         rd_data = DW'(sh_off);
      end else if (hit_status) begin
         rd_data[0] = commit_pending;
      end
   end
`else
   assign rd_ok   = 1'b0;
   assign rd_data = '0;
`endif

   always_comb begin
      resp_cmd_nxt        = '0;
      resp_cmd_nxt[4:0]   = is_read ? RESP_READ : RESP_WRITE;
      resp_cmd_nxt[15:5]  = cfg_req_cmd[15:5];
      if (is_read ? !rd_ok : !wr_ok) begin
         resp_cmd_nxt[26:25] = 2'b11;
      end
   end

   always_comb begin
      state_nxt      = state;
      cfg_req_ready  = 1'b0;
      cfg_resp_valid = 1'b0;
      case (state)
         IDLE: begin
            cfg_req_ready = 1'b1;
            if (cfg_req_valid && !is_posted) state_nxt = RESP;
         end
         RESP: begin
            cfg_resp_valid = 1'b1;
            if (cfg_resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req_fire = cfg_req_valid & cfg_req_ready;
   assign wr_en    = req_fire & wr_ok;
   assign apply    = commit_pending & remap_idle;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cfg_resp_cmd     <= '0;
         cfg_resp_dstaddr <= '0;
         cfg_resp_srcaddr <= '0;
         cfg_resp_data    <= '0;
      end else if (req_fire && !is_posted) begin
         cfg_resp_cmd     <= resp_cmd_nxt;
         cfg_resp_dstaddr <= cfg_req_srcaddr;
         cfg_resp_srcaddr <= cfg_req_dstaddr;
         cfg_resp_data    <= rd_ok ? rd_data : '0;
      end
   end

   // Commit copies the pre-edge shadows, so a write landing on the same edge stays in the shadow only.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < NMAPS; i++) begin
            sh_old[i]  <= IDW'(i);
            sh_new[i]  <= IDW'(i);
            act_old[i] <= IDW'(i);
            act_new[i] <= IDW'(i);
         end
         sh_low                <= '1;
         sh_high               <= '0;
         sh_off                <= '0;
         set_dstaddress_low    <= '1;
         set_dstaddress_high   <= '0;
         set_dstaddress_offset <= '0;
         commit_pending        <= 1'b0;
      end else begin
         if (apply) begin
            act_old               <= sh_old;
            act_new               <= sh_new;
            set_dstaddress_low    <= sh_low;
            set_dstaddress_high   <= sh_high;
            set_dstaddress_offset <= sh_off;
         end
         if (wr_en) begin
            if (hit_entry) begin
               sh_old[idx] <= cfg_req_data[IDW-1:0];
               sh_new[idx] <= cfg_req_data[IDW+31:32];
            end
            if (hit_low)  sh_low  <= AW'(cfg_req_data);
            if (hit_high) sh_high <= AW'(cfg_req_data);
            if (hit_off)  sh_off  <= AW'(cfg_req_data);
         end
         if (wr_en && hit_ctrl && cfg_req_data[0]) commit_pending <= 1'b1;
         else if (apply)                           commit_pending <= 1'b0;
      end
   end

   generate
      for (genvar i = 0; i < NMAPS; i++) begin : g_pack
         assign old_row_col_address[IDW*i +: IDW] = act_old[i];
         assign new_row_col_address[IDW*i +: IDW] = act_new[i];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_umi_address_remap_cfg.sv
`default_nettype none
// tb_umi_address_remap_cfg: scoreboard bench with a register-map reference model.
module tb_umi_address_remap_cfg;
   localparam int CW = 32, AW = 64, DW = 64, IDW = 16, NMAPS = 8;
`ifdef UMI_REMAP_CFG_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic clk = 1'b0;
   logic nreset = 1'b0;
   always #5 clk = ~clk;

   logic                 cfg_req_valid, cfg_req_ready, cfg_resp_valid, cfg_resp_ready;
   logic [CW-1:0]        cfg_req_cmd, cfg_resp_cmd;
   logic [AW-1:0]        cfg_req_dstaddr, cfg_req_srcaddr, cfg_resp_dstaddr, cfg_resp_srcaddr;
   logic [DW-1:0]        cfg_req_data, cfg_resp_data;
   logic                 remap_idle, commit_pending;
   logic [IDW*NMAPS-1:0] old_rc, new_rc;
   logic [AW-1:0]        win_low, win_high, win_off;

   umi_address_remap_cfg #(.CW(CW), .AW(AW), .DW(DW), .IDW(IDW), .NMAPS(NMAPS)) dut (
      .clk(clk), .nreset(nreset),
      .cfg_req_valid(cfg_req_valid), .cfg_req_ready(cfg_req_ready),
      .cfg_req_cmd(cfg_req_cmd), .cfg_req_dstaddr(cfg_req_dstaddr),
      .cfg_req_srcaddr(cfg_req_srcaddr), .cfg_req_data(cfg_req_data),
      .cfg_resp_valid(cfg_resp_valid), .cfg_resp_ready(cfg_resp_ready),
      .cfg_resp_cmd(cfg_resp_cmd), .cfg_resp_dstaddr(cfg_resp_dstaddr),
      .cfg_resp_srcaddr(cfg_resp_srcaddr), .cfg_resp_data(cfg_resp_data),
      .remap_idle(remap_idle),
      .old_row_col_address(old_rc), .new_row_col_address(new_rc),
      .set_dstaddress_low(win_low), .set_dstaddress_high(win_high),
      .set_dstaddress_offset(win_off), .commit_pending(commit_pending)
   );

   typedef struct {
      logic [CW-1:0] cmd;
      logic [AW-1:0] dst;
      logic [AW-1:0] src;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   fire = 1'b0;
   bit   force_low = 1'b0;
   logic [IDW*NMAPS-1:0] id_pack;

   // Reference register file: shadow (m_*) and active (a_*) copies.
   logic [IDW-1:0] m_old[NMAPS], m_new[NMAPS], a_old[NMAPS], a_new[NMAPS];
   logic [AW-1:0]  m_low, m_high, m_off, a_low, a_high, a_off;
   bit             m_pend;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NMAPS; i++) begin
         m_old[i] = IDW'(i); m_new[i] = IDW'(i);
         a_old[i] = IDW'(i); a_new[i] = IDW'(i);
      end
      m_low = '1; m_high = '0; m_off = '0;
      a_low = '1; a_high = '0; a_off = '0;
      m_pend = 1'b0;
   endfunction

   function automatic logic [IDW*NMAPS-1:0] pack(input logic [IDW-1:0] a[NMAPS]);
      logic [IDW*NMAPS-1:0] v;
      for (int i = 0; i < NMAPS; i++) v[IDW*i +: IDW] = a[i];
      return v;
   endfunction

   always @(posedge clk or negedge nreset) begin : model
      logic [11:0] off;
      logic [4:0]  opc;
      bit          shape, entry, mapped, is_rd, is_wr, ok, dowr, setc, doc;
      int          idx;
      rsp_t        r;
      if (!nreset) begin
         model_reset();
         exp_q.delete();
      end else begin
         doc = m_pend && remap_idle;
         dowr = 1'b0; setc = 1'b0; idx = 0; off = '0;
         if (fire) begin
            opc    = cfg_req_cmd[4:0];
            off    = cfg_req_dstaddr[11:0];
            shape  = (cfg_req_cmd[7:5] == 3'd3) && (cfg_req_cmd[15:8] == 8'd0);
            entry  = (off < 12'(8 * NMAPS)) && (off % 8 == 0);
            idx    = int'(off / 8);
            mapped = entry || (off inside {12'h100, 12'h108, 12'h110, 12'h118, 12'h120});
            is_rd  = (opc == 5'h01);
            is_wr  = (opc == 5'h03) || (opc == 5'h05);
            ok     = shape && mapped && (is_rd ? RB : (is_wr && off != 12'h120));
            r.cmd = '0;
            r.cmd[4:0]  = is_rd ? 5'h02 : 5'h04;
            r.cmd[15:5] = cfg_req_cmd[15:5];
            if (!ok) r.cmd[26:25] = 2'b11;
            r.dst  = cfg_req_srcaddr;
            r.src  = cfg_req_dstaddr;
            r.data = '0;
            if (is_rd && ok) begin
               if (entry)               r.data = 64'(m_old[idx]) | (64'(m_new[idx]) << 32);
               else if (off == 12'h100) r.data = m_low;
               else if (off == 12'h108) r.data = m_high;
               else if (off == 12'h110) r.data = m_off;
               else if (off == 12'h120) r.data = 64'(m_pend);
            end
            if (opc != 5'h05) exp_q.push_back(r);
            dowr = ok && is_wr;
            setc = dowr && (off == 12'h118) && cfg_req_data[0];
         end
         if (doc) begin
            a_old = m_old; a_new = m_new;
            a_low = m_low; a_high = m_high; a_off = m_off;
            m_pend = 1'b0;
         end
         if (dowr) begin
            if (off < 12'(8 * NMAPS)) begin
               m_old[idx] = cfg_req_data[IDW-1:0];
               m_new[idx] = cfg_req_data[IDW+31:32];
            end
            if (off == 12'h100) m_low  = cfg_req_data;
            if (off == 12'h108) m_high = cfg_req_data;
            if (off == 12'h110) m_off  = cfg_req_data;
         end
         if (setc) m_pend = 1'b1;
      end
   end

   // Monitor: compare every presented response against the scoreboard head; pop on handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (nreset) begin
            chk("act_old", old_rc, pack(a_old));
            chk("act_new", new_rc, pack(a_new));
            chk("act_low", win_low, a_low);
            chk("act_high", win_high, a_high);
            chk("act_offset", win_off, a_off);
            chk("commit_pending", commit_pending, m_pend);
            if (cfg_resp_valid) begin
               chk("req_ready_in_resp", cfg_req_ready, 1'b0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_resp", 1'b1, 1'b0);
               end else begin
                  chk("resp_cmd", cfg_resp_cmd, exp_q[0].cmd);
                  chk("resp_dstaddr", cfg_resp_dstaddr, exp_q[0].dst);
                  chk("resp_srcaddr", cfg_resp_srcaddr, exp_q[0].src);
                  chk("resp_data", cfg_resp_data, exp_q[0].data);
                  if (cfg_resp_ready) void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      cfg_resp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cfg_resp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [4:0] opc, input logic [2:0] size, input logic [7:0] len,
                       input logic [11:0] off, input logic [DW-1:0] data, input logic [AW-1:0] src);
      logic [AW-1:0] d;
      int n;
      @(negedge clk);
      d = {$urandom(), $urandom()};
      d[11:0] = off;
      cfg_req_cmd     = '0;
      cfg_req_cmd[4:0]  = opc;
      cfg_req_cmd[7:5]  = size;
      cfg_req_cmd[15:8] = len;
      cfg_req_dstaddr = d;
      cfg_req_srcaddr = src;
      cfg_req_data    = data;
      cfg_req_valid   = 1'b1;
      n = 0;
      while (!cfg_req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_req_ready) begin
         chk("req_accept_timeout", 1'b0, 1'b1);
         cfg_req_valid = 1'b0;
         return;
      end
      fire = 1'b1;
      @(posedge clk);
      #1;
      fire = 1'b0;
      cfg_req_valid = 1'b0;
      @(negedge clk);
      chk("resp_latency", cfg_resp_valid, opc != 5'h05);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || cfg_resp_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", exp_q.size() == 0, 1'b1);
   endtask

   initial begin
      logic [11:0] offs[14];
      offs = '{12'h000, 12'h008, 12'h010, 12'h018, 12'h020, 12'h028, 12'h030, 12'h038,
               12'h100, 12'h108, 12'h110, 12'h118, 12'h120, 12'h200};
      model_reset();
      for (int i = 0; i < NMAPS; i++) id_pack[IDW*i +: IDW] = IDW'(i);
      cfg_req_valid = 1'b0; cfg_req_cmd = '0; cfg_req_dstaddr = '0;
      cfg_req_srcaddr = '0; cfg_req_data = '0; remap_idle = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_resp_valid", cfg_resp_valid, 1'b0);
      chk("rst_req_ready", cfg_req_ready, 1'b1);
      chk("rst_resp_cmd", cfg_resp_cmd, '0);
      chk("rst_resp_dst", cfg_resp_dstaddr, '0);
      chk("rst_resp_src", cfg_resp_srcaddr, '0);
      chk("rst_resp_data", cfg_resp_data, '0);
      chk("rst_pending", commit_pending, 1'b0);
      chk("rst_old", old_rc, id_pack);
      chk("rst_new", new_rc, id_pack);
      chk("rst_low", win_low, {AW{1'b1}});
      chk("rst_high", win_high, '0);
      chk("rst_offset", win_off, '0);
      nreset = 1'b1;

      send(5'h01, 3'd3, 8'd0, 12'h110, '0, 64'h10);
      send(5'h01, 3'd3, 8'd0, 12'h100, '0, 64'h11);
      send(5'h01, 3'd3, 8'd0, 12'h108, '0, 64'h12);
      send(5'h01, 3'd3, 8'd0, 12'h018, '0, 64'h13);
      send(5'h03, 3'd3, 8'd0, 12'h100, 64'h0000_0600_0000_0080, 64'h1234);
      drain();
      chk("low_before_commit", win_low, {AW{1'b1}});

      // Commit held off by a busy remapper
      remap_idle = 1'b0;
      send(5'h03, 3'd3, 8'd0, 12'h010, 64'h0000_FFFD_0000_0002, 64'h20);
      send(5'h03, 3'd3, 8'd0, 12'h118, 64'h1, 64'h21);
      repeat (10) @(negedge clk);
      chk("pending_while_busy", commit_pending, 1'b1);
      chk("entry2_new_held", new_rc[47:32], 16'h0002);
      send(5'h01, 3'd3, 8'd0, 12'h120, '0, 64'h22);
      drain();
      remap_idle = 1'b1;
      @(negedge clk);
      chk("pending_cleared", commit_pending, 1'b0);
      chk("entry2_new_applied", new_rc[47:32], 16'hFFFD);
      chk("low_applied", win_low, 64'h0000_0600_0000_0080);
      send(5'h01, 3'd3, 8'd0, 12'h120, '0, 64'h23);

      // Illegal accesses and posted writes
      send(5'h03, 3'd2, 8'd0, 12'h110, 64'hDEAD, 64'h30);
      send(5'h03, 3'd3, 8'd1, 12'h110, 64'hBEEF, 64'h31);
      send(5'h01, 3'd3, 8'd0, 12'h200, '0, 64'h32);
      send(5'h03, 3'd3, 8'd0, 12'h120, 64'h1, 64'h33);
      send(5'h07, 3'd3, 8'd0, 12'h110, 64'h1, 64'h34);
      send(5'h05, 3'd3, 8'd0, 12'h110, 64'h0000_0000_0000_4000, 64'h35);
      send(5'h05, 3'd1, 8'd0, 12'h108, 64'h5555, 64'h36);
      send(5'h01, 3'd3, 8'd0, 12'h110, '0, 64'h37);
      drain();

      // Response back-pressure
      force_low = 1'b1;
      send(5'h03, 3'd3, 8'd0, 12'h108, 64'h0000_0700_0000_0000, 64'h40);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_req_ready", cfg_req_ready, 1'b0);
         chk("stall_resp_valid", cfg_resp_valid, 1'b1);
      end
      fork
         begin
            repeat (3) @(negedge clk);
            force_low = 1'b0;
         end
      join_none
      send(5'h01, 3'd3, 8'd0, 12'h108, '0, 64'h41);
      drain();

      // Randomized traffic
      for (int t = 0; t < 300; t++) begin
         logic [4:0] opc;
         logic [2:0] sz;
         logic [7:0] ln;
         logic [11:0] o;
         int k;
         k = $urandom_range(0, 9);
         if (k < 4)      opc = 5'h01;
         else if (k < 7) opc = 5'h03;
         else if (k < 9) opc = 5'h05;
         else            opc = 5'($urandom());
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom()) : 3'd3;
         ln = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : 8'd0;
         o  = ($urandom_range(0, 9) == 0) ? 12'($urandom()) : offs[$urandom_range(0, 13)];
         remap_idle = ($urandom_range(0, 3) != 0);
         send(opc, sz, ln, o, {$urandom(), $urandom()}, {$urandom(), $urandom()});
      end
      remap_idle = 1'b1;
      drain();

      // Reset while a response and a commit are outstanding
      remap_idle = 1'b0;
      send(5'h03, 3'd3, 8'd0, 12'h000, 64'h0000_0009_0000_0009, 64'h50);
      send(5'h03, 3'd3, 8'd0, 12'h118, 64'h1, 64'h51);
      force_low = 1'b1;
      send(5'h01, 3'd3, 8'd0, 12'h000, '0, 64'h52);
      @(posedge clk);
      #2;
      nreset = 1'b0;
      @(negedge clk);
      chk("rst2_resp_valid", cfg_resp_valid, 1'b0);
      chk("rst2_pending", commit_pending, 1'b0);
      chk("rst2_old", old_rc, id_pack);
      chk("rst2_new", new_rc, id_pack);
      chk("rst2_low", win_low, {AW{1'b1}});
      chk("rst2_high", win_high, '0);
      chk("rst2_offset", win_off, '0);
      nreset = 1'b1;
      force_low = 1'b0;
      remap_idle = 1'b1;
      send(5'h01, 3'd3, 8'd0, 12'h018, '0, 64'h53);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
`default_nettype wire
